// File: rtl/cellrv32_fifo.sv
// ---------------------------------------------------------------------------
// cellrv32_fifo
// Generic single-clock ring-buffer FIFO. It is the RX/TX data buffer for the
// byte-oriented peripherals. Status flags feed the peripheral status
// registers and the IRQ logic.
//
// Parameters
//   FIFO_DEPTH : number of entries, power of two, 1..32768
//   FIFO_WIDTH : data element width
//   FIFO_RSYNC : 0 = combinational head read, 1 = registered read data
//   FIFO_SAFE  : 1 = drop writes when full and reads when empty
//   FIFO_GATE  : 1 = rdata_o is all-zero while no valid data is presented
//
// Ports
//   clk_i    in   clock, rising edge
//   rst_i    in   asynchronous reset, active-high
//   clear_i  in   synchronous clear (pointers to zero), beats we_i/re_i
//   wdata_i  in   write data
//   we_i     in   write enable (push)
//   re_i     in   read enable (pop head entry)
//   rdata_o  out  head entry
//   free_o   out  at least one entry free (not full)
//   avail_o  out  at least one entry valid (not empty)
//   half_o   out  fill level >= FIFO_DEPTH/2 (full when FIFO_DEPTH = 1)
// ---------------------------------------------------------------------------
module cellrv32_fifo #(
    parameter int FIFO_DEPTH = 1,
    parameter int FIFO_WIDTH = 32,
    parameter int FIFO_RSYNC = 0,
    parameter int FIFO_SAFE  = 0,
    parameter int FIFO_GATE  = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    output logic                  half_o,
    input  logic [FIFO_WIDTH-1:0] wdata_i,
    input  logic                  we_i,
    output logic                  free_o,
    input  logic                  re_i,
    output logic [FIFO_WIDTH-1:0] rdata_o,
    output logic                  avail_o
);

    // Index width; a one-entry FIFO still needs a legal 1-bit index.
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int IDX_W = (AW == 0) ? 1 : AW;
    localparam logic [AW:0] HALF_LVL = (AW + 1)'(FIFO_DEPTH / 2);

    if ((FIFO_DEPTH < 1) || (FIFO_DEPTH > 32768) ||
        ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
        $error("cellrv32_fifo: FIFO_DEPTH must be a power of two in 1..32768");
    end

    // Pointers carry one extra MSB as a wrap flag so full and empty differ.
    logic [AW:0]            r_wptr;
    logic [AW:0]            r_rptr;
    logic [IDX_W-1:0]       w_widx;
    logic [IDX_W-1:0]       w_ridx;
    logic [AW:0]            w_level;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_we;
    logic                   w_re;
    logic [FIFO_WIDTH-1:0]  w_data;
    logic                   w_valid;

    logic [FIFO_WIDTH-1:0]  r_mem [FIFO_DEPTH];

    if (AW == 0) begin : g_idx_single
        assign w_widx = 1'b0;
        assign w_ridx = 1'b0;
        assign w_full = (r_wptr[0] != r_rptr[0]);
    end else begin : g_idx_multi
        assign w_widx = r_wptr[AW-1:0];
        assign w_ridx = r_rptr[AW-1:0];
        assign w_full = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) &&
                        (r_wptr[AW] != r_rptr[AW]);
    end

    assign w_empty = (r_wptr == r_rptr);
    assign w_level = r_wptr - r_rptr;

    assign free_o  = ~w_full;
    assign avail_o = ~w_empty;
    assign half_o  = (FIFO_DEPTH == 1) ? w_full : (w_level >= HALF_LVL);

    // Safe mode masks the strobes; unsafe mode lets the pointers run free.
    assign w_we = we_i & ((FIFO_SAFE != 0) ? ~w_full  : 1'b1);
    assign w_re = re_i & ((FIFO_SAFE != 0) ? ~w_empty : 1'b1);

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (clear_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_we) r_wptr <= r_wptr + 1'b1;
            if (w_re) r_rptr <= r_rptr + 1'b1;
        end
    end

    // NOTE: the storage array has no reset so it can map onto RAM; the
    // pointers alone define which entries are meaningful.
    always_ff @(posedge clk_i) begin
        if (w_we && !clear_i) begin
            r_mem[w_widx] <= wdata_i;
        end
    end

    if (FIFO_RSYNC != 0) begin : g_rsync
        logic [FIFO_WIDTH-1:0] r_rdata;
        logic                  r_gate;

        // Valid flag is registered alongside the data so the gate lines up
        // with what is actually on the output.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_rdata <= '0;
                r_gate  <= 1'b0;
            end else begin
                r_rdata <= r_mem[w_ridx];
                r_gate  <= ~w_empty;
            end
        end

        assign w_data  = r_rdata;
        assign w_valid = r_gate;
    end else begin : g_rasync
        assign w_data  = r_mem[w_ridx];
        assign w_valid = ~w_empty;
    end

    assign rdata_o = (FIFO_GATE != 0) ? (w_valid ? w_data : '0) : w_data;

endmodule

// File: tb/tb_cellrv32_fifo.sv
// ---------------------------------------------------------------------------
// tb_cellrv32_fifo
// Four FIFO configurations share one stimulus stream. Each has a queue-based
// reference model; every cycle all outputs are compared with the model, and
// directed checks pin down the scenario-specific values.
//   inst 0: DEPTH 4, async read, gated
//   inst 1: DEPTH 2, async read, gated
//   inst 2: DEPTH 1, sync read,  gated
//   inst 3: DEPTH 8, sync read,  gated
// All instances use safe mode and 8-bit data.
// ---------------------------------------------------------------------------
module tb_cellrv32_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       we;
    logic       re;
    logic [7:0] wdata;

    logic [3:0] avail_v;
    logic [3:0] free_v;
    logic [3:0] half_v;
    logic [7:0] rd_v [4];

    int checks = 0;
    int errors = 0;

    // Reference model: contents as a queue, plus the registered output for
    // the sync-read instances.
    int         dep     [4] = '{4, 2, 1, 8};
    bit         is_sync [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] mq      [4][$];
    logic [7:0] sreg    [4];

    always #5 clk = ~clk;

    cellrv32_fifo #(.FIFO_DEPTH(4), .FIFO_WIDTH(8), .FIFO_RSYNC(0),
                    .FIFO_SAFE(1), .FIFO_GATE(1)) u_f0 (
        .clk_i(clk), .rst_i(rst), .clear_i(clr), .half_o(half_v[0]),
        .wdata_i(wdata), .we_i(we), .free_o(free_v[0]), .re_i(re),
        .rdata_o(rd_v[0]), .avail_o(avail_v[0]));

    cellrv32_fifo #(.FIFO_DEPTH(2), .FIFO_WIDTH(8), .FIFO_RSYNC(0),
                    .FIFO_SAFE(1), .FIFO_GATE(1)) u_f1 (
        .clk_i(clk), .rst_i(rst), .clear_i(clr), .half_o(half_v[1]),
        .wdata_i(wdata), .we_i(we), .free_o(free_v[1]), .re_i(re),
        .rdata_o(rd_v[1]), .avail_o(avail_v[1]));

    cellrv32_fifo #(.FIFO_DEPTH(1), .FIFO_WIDTH(8), .FIFO_RSYNC(1),
                    .FIFO_SAFE(1), .FIFO_GATE(1)) u_f2 (
        .clk_i(clk), .rst_i(rst), .clear_i(clr), .half_o(half_v[2]),
        .wdata_i(wdata), .we_i(we), .free_o(free_v[2]), .re_i(re),
        .rdata_o(rd_v[2]), .avail_o(avail_v[2]));

    cellrv32_fifo #(.FIFO_DEPTH(8), .FIFO_WIDTH(8), .FIFO_RSYNC(1),
                    .FIFO_SAFE(1), .FIFO_GATE(1)) u_f3 (
        .clk_i(clk), .rst_i(rst), .clear_i(clr), .half_o(half_v[3]),
        .wdata_i(wdata), .we_i(we), .free_o(free_v[3]), .re_i(re),
        .rdata_o(rd_v[3]), .avail_o(avail_v[3]));

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mq[i].delete();
            sreg[i] = 8'h00;
        end
    endtask

    // One clock edge of the model, computed from pre-edge contents.
    task automatic model_edge(input logic w, input logic [7:0] d,
                              input logic r, input logic c);
        for (int i = 0; i < 4; i++) begin
            int sz = mq[i].size();
            sreg[i] = (sz > 0) ? mq[i][0] : 8'h00;
            if (c) begin
                mq[i].delete();
            end else begin
                if (r && sz > 0)      void'(mq[i].pop_front());
                if (w && sz < dep[i]) mq[i].push_back(d);
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 4; i++) begin
            int         sz = mq[i].size();
            logic       e_half;
            logic [7:0] e_rd;
            e_half = (dep[i] == 1) ? (sz == 1) : (sz >= dep[i] / 2);
            if (is_sync[i]) e_rd = sreg[i];
            else            e_rd = (sz > 0) ? mq[i][0] : 8'h00;
            check($sformatf("m%0d_avail", i), 32'(avail_v[i]), 32'(sz > 0));
            check($sformatf("m%0d_free", i),  32'(free_v[i]),  32'(sz < dep[i]));
            check($sformatf("m%0d_half", i),  32'(half_v[i]),  32'(e_half));
            check($sformatf("m%0d_rdata", i), 32'(rd_v[i]),    32'(e_rd));
        end
    endtask

    task automatic step(input logic w, input logic [7:0] d,
                        input logic r, input logic c);
        we    = w;
        wdata = d;
        re    = r;
        clr   = c;
        @(posedge clk);
        model_edge(w, d, r, c);
        #1;
        compare_all();
        we  = 1'b0;
        re  = 1'b0;
        clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; we = 1'b0; re = 1'b0; wdata = 8'h00;
        model_reset();
        #2;
        compare_all();
        check("rst_avail", 32'(avail_v[0]), 32'd0);
        check("rst_free",  32'(free_v[0]),  32'd1);
        check("rst_half",  32'(half_v[0]),  32'd0);
        #10;
        rst = 1'b0;
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a sequence.
        step(1'b1, 8'h77, 1'b0, 1'b0);
        step(1'b1, 8'h88, 1'b0, 1'b0);
        check("pre_rst_avail", 32'(avail_v[0]), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        check("async_rst_avail", 32'(avail_v[0]), 32'd0);
        check("async_rst_free",  32'(free_v[0]),  32'd1);
        check("async_rst_half",  32'(half_v[0]),  32'd0);
        check("async_rst_rdata", 32'(rd_v[0]),    32'h00);
        check("async_rst_rd3",   32'(rd_v[3]),    32'h00);
        #1;
        rst = 1'b0;

        // Fill / drain, DEPTH 4.
        step(1'b1, 8'h11, 1'b0, 1'b0);
        check("fill1_half", 32'(half_v[0]), 32'd0);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        check("fill2_half", 32'(half_v[0]), 32'd1);
        step(1'b1, 8'h33, 1'b0, 1'b0);
        check("fill3_free", 32'(free_v[0]), 32'd1);
        step(1'b1, 8'h44, 1'b0, 1'b0);
        check("fill4_free", 32'(free_v[0]), 32'd0);
        step(1'b1, 8'h55, 1'b0, 1'b0);
        check("ovf_free",  32'(free_v[0]), 32'd0);
        check("ovf_head",  32'(rd_v[0]),   32'h11);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("drain%0d", k), 32'(rd_v[0]), 32'(8'h11 * (k + 1)));
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        check("drain_avail", 32'(avail_v[0]), 32'd0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("udf_avail", 32'(avail_v[0]), 32'd0);

        // Wrap-around: 10 write/read pairs through DEPTH 4.
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 8'(k), 1'b0, 1'b0);
            check($sformatf("wrap_rd%0d", k),    32'(rd_v[0]),    32'(k));
            check($sformatf("wrap_avail%0d", k), 32'(avail_v[0]), 32'd1);
            step(1'b0, 8'h00, 1'b1, 1'b0);
            check($sformatf("wrap_empty%0d", k), 32'(avail_v[0]), 32'd0);
        end

        // Simultaneous push/pop on full and empty, DEPTH 2.
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        step(1'b1, 8'hBB, 1'b0, 1'b0);
        check("sim_full", 32'(free_v[1]), 32'd0);
        step(1'b1, 8'hCC, 1'b1, 1'b0);
        check("sim_full_rd",    32'(rd_v[1]),    32'hBB);
        check("sim_full_free",  32'(free_v[1]),  32'd1);
        check("sim_full_avail", 32'(avail_v[1]), 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("sim_drained", 32'(avail_v[1]), 32'd0);
        step(1'b1, 8'hDD, 1'b1, 1'b0);
        check("sim_empty_rd",    32'(rd_v[1]),    32'hDD);
        check("sim_empty_avail", 32'(avail_v[1]), 32'd1);
        check("sim_empty_half",  32'(half_v[1]),  32'd1);
        check("sim_empty_free",  32'(free_v[1]),  32'd1);

        // Sync read with gate, DEPTH 1.
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        check("sg_avail_k",  32'(avail_v[2]), 32'd1);
        check("sg_half_k",   32'(half_v[2]),  32'd1);
        check("sg_rd_k",     32'(rd_v[2]),    32'h00);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("sg_rd_k1",    32'(rd_v[2]),    32'hA5);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("sg_pop_avail", 32'(avail_v[2]), 32'd0);
        check("sg_pop_rd",    32'(rd_v[2]),    32'hA5);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("sg_pop_rd1",   32'(rd_v[2]),    32'h00);

        // Clear beats a same-cycle write, DEPTH 8.
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'h01, 1'b0, 1'b0);
        step(1'b1, 8'h02, 1'b0, 1'b0);
        step(1'b1, 8'h03, 1'b0, 1'b0);
        check("clr_pre_avail", 32'(avail_v[3]), 32'd1);
        check("clr_pre_half",  32'(half_v[3]),  32'd0);
        step(1'b1, 8'hEE, 1'b0, 1'b1);
        check("clr_avail", 32'(avail_v[3]), 32'd0);
        check("clr_free",  32'(free_v[3]),  32'd1);
        check("clr_half",  32'(half_v[3]),  32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("clr_rd", 32'(rd_v[3]), 32'h00);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 24) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
